// File: rtl/seq_pkg.sv
// Shared types and encodings for the instruction sequencer.
// States, opcode and op-field constants used by decode and control.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD_IR,
    CHECK,
    ISSUE,
    EXEC,
    HALTED
  } state_t;

  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;

endpackage

// File: rtl/seq_decode_check.sv
// Combinational legality screen on the IR opcode/op fields.
// Ports: ir_hi = ir[15:11] in; legal, is_halt out.
module seq_decode_check
  import seq_pkg::*;
(
  input  logic [4:0] ir_hi,
  output logic       legal,
  output logic       is_halt
);

  logic [2:0] opc;
  logic [1:0] op;

  assign opc = ir_hi[4:2];
  assign op  = ir_hi[1:0];

  always_comb begin
    legal   = 1'b0;
    is_halt = 1'b0;
    unique case (1'b1)
      (opc == OPC_ALU):  legal = 1'b1;
      (opc == OPC_MOV):  legal = (op == MOV_IMM) || (op == MOV_REG);
      (opc == OPC_HALT): is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer: IR load, legality screen, s/w handshake, watchdog.
// Ports: clk, reset, run, step, halt_req, pc_load, pc_din, mem_rd,
//  mem_addr, mem_rdata, ir, s, w, pc, halted, illegal, fault, retired.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  input  logic                halt_req,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] pc_din,
  output logic                mem_rd,
  output logic [PC_WIDTH-1:0] mem_addr,
  input  logic [15:0]         mem_rdata,
  output logic [15:0]         ir,
  output logic                s,
  input  logic                w,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                illegal,
  output logic                fault,
  output logic [15:0]         retired
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  state_t        state;
  logic          pend;
  logic          step_mode;
  logic [WW-1:0] wdog;
  logic          legal;
  logic          is_halt;

  seq_decode_check u_dec (
    .ir_hi   (ir[15:11]),
    .legal   (legal),
    .is_halt (is_halt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      fault     <= 1'b0;
      retired   <= '0;
      pend      <= 1'b0;
      step_mode <= 1'b0;
      wdog      <= '0;
    end else begin
      // Later per-state clears override this.
      if (halt_req && state != HALTED)
        pend <= 1'b1;
      unique case (state)
        IDLE: begin
          pend <= 1'b0;
          if (pc_load) begin
            pc      <= pc_din;
            halted  <= 1'b0;
            illegal <= 1'b0;
            fault   <= 1'b0;
          end else if (halt_req) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (run || step) begin
            state     <= FETCH;
            step_mode <= step;
          end
        end
        FETCH: state <= LOAD_IR;
        LOAD_IR: begin
          ir    <= mem_rdata;
          pc    <= pc + 1'b1;
          state <= CHECK;
        end
        CHECK: begin
          if (is_halt || !legal) begin
            state     <= HALTED;
            halted    <= 1'b1;
            illegal   <= !is_halt;
            pend      <= 1'b0;
            step_mode <= 1'b0;
          end else begin
            state <= ISSUE;
            wdog  <= '0;
          end
        end
        ISSUE: begin
          if (!w) begin
            state <= EXEC;
            wdog  <= '0;
          end else if (wdog == WD_LAST) begin
            state     <= HALTED;
            halted    <= 1'b1;
            fault     <= 1'b1;
            pend      <= 1'b0;
            step_mode <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        EXEC: begin
          if (w) begin
            retired <= retired + 1'b1;
            if (pend || halt_req) begin
              state     <= HALTED;
              halted    <= 1'b1;
              pend      <= 1'b0;
              step_mode <= 1'b0;
            end else if (step_mode || !run) begin
              state     <= IDLE;
              pend      <= 1'b0;
              step_mode <= 1'b0;
            end else begin
              state <= FETCH;
            end
          end else if (wdog == WD_LAST) begin
            state     <= HALTED;
            halted    <= 1'b1;
            fault     <= 1'b1;
            pend      <= 1'b0;
            step_mode <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        HALTED: begin
          if (pc_load) begin
            state   <= IDLE;
            pc      <= pc_din;
            halted  <= 1'b0;
            illegal <= 1'b0;
            fault   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s        = (state == ISSUE);
    mem_rd   = (state == FETCH);
    mem_addr = pc;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer.
// Stub memory and core; program-level reference model.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        halt_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [7:0]  pc_din = 8'h00;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] ir;
  logic        s;
  logic        w;
  logic [7:0]  pc;
  logic        halted;
  logic        illegal;
  logic        fault;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  instr_sequencer #(
    .PC_WIDTH (8),
    .RESET_PC (8'h00),
    .TIMEOUT  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .halt_req  (halt_req),
    .pc_load   (pc_load),
    .pc_din    (pc_din),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .s         (s),
    .w         (w),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal),
    .fault     (fault),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];

  always @(posedge clk)
    if (mem_rd) mem_rdata <= mem[mem_addr];

  // Stub core: busy for core_lat cycles after seeing s while idle.
  logic core_busy = 1'b0;
  int   core_cnt = 0;
  int   core_lat = 3;
  bit   core_hang = 1'b0;

  assign w = !core_busy;

  always @(posedge clk) begin
    if (reset) begin
      core_busy <= 1'b0;
    end else if (!core_busy) begin
      if (s) begin
        core_busy <= 1'b1;
        core_cnt  <= core_lat;
      end
    end else if (!core_hang) begin
      if (core_cnt <= 1) core_busy <= 1'b0;
      else core_cnt <= core_cnt - 1;
    end
  end

  int   s_rises = 0;
  int   rd_cnt = 0;
  logic s_q = 1'b0;

  always @(posedge clk) begin
    if (s && !s_q) s_rises <= s_rises + 1;
    s_q <= s;
    if (mem_rd) rd_cnt <= rd_cnt + 1;
  end

  function automatic bit ref_legal(input logic [15:0] i);
    case (i[15:11])
      5'b10100, 5'b10101, 5'b10110, 5'b10111,
      5'b11000, 5'b11010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] gen_instr();
    logic [15:0] v;
    int k;
    v = 16'($urandom);
    k = $urandom_range(0, 9);
    if (k == 0) v[15:13] = 3'($urandom_range(0, 4));
    else if (k == 1) begin
      v[15:13] = 3'b110;
      v[12:11] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
    end else if (k < 5) v[15:13] = 3'b101;
    else begin
      v[15:13] = 3'b110;
      v[12:11] = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b00;
    end
    return v;
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run = 1'b0;
    step = 1'b0;
    halt_req = 1'b0;
    pc_load = 1'b0;
    pc_din = 8'h00;
    core_hang = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_pc(input logic [7:0] v);
    pc_load = 1'b1;
    pc_din = v;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string nm);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s_halt_timeout got=%b want=1", nm, halted);
    end
  endtask

  task automatic test_reset();
    fill_halt();
    do_reset();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h want=00", pc); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got=%h want=0000", ir); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL reset_s got=%b want=0", s); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got=%b want=0", mem_rd); end
    checks++; if ({halted, illegal, fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {halted, illegal, fault}); end
    checks++; if (retired !== 16'h0000) begin errors++; $display("FAIL reset_retired got=%0d want=0", retired); end
  endtask

  task automatic test_run_halt();
    int s0, lat;
    fill_halt();
    mem[0] = 16'hD007;
    mem[1] = 16'hE000;
    do_reset();
    core_lat = 3;
    s0 = s_rises;
    run = 1'b1;
    lat = 0;
    while (!s && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL run_latency got=%0d want=4", lat); end
    wait_halt(100, "run");
    run = 1'b0;
    checks++; if (s_rises - s0 != 1) begin errors++; $display("FAIL run_issues got=%0d want=1", s_rises - s0); end
    checks++; if (pc !== 8'h02) begin errors++; $display("FAIL run_pc got=%h want=02", pc); end
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL run_retired got=%0d want=1", retired); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL run_illegal got=%b want=0", illegal); end
    checks++; if (ir !== 16'hE000) begin errors++; $display("FAIL run_ir got=%h want=E000", ir); end
  endtask

  task automatic test_step();
    int s0, r0;
    fill_halt();
    mem[0] = 16'hA240;
    mem[1] = 16'hD005;
    do_reset();
    core_lat = 2;
    s0 = s_rises;
    r0 = rd_cnt;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (s_rises - s0 != 1) begin errors++; $display("FAIL step_issues got=%0d want=1", s_rises - s0); end
    checks++; if (rd_cnt - r0 != 1) begin errors++; $display("FAIL step_reads got=%0d want=1", rd_cnt - r0); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL step_pc got=%h want=01", pc); end
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL step_retired got=%0d want=1", retired); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL step_halted got=%b want=0", halted); end
  endtask

  task automatic test_illegal();
    int s0;
    fill_halt();
    mem[0] = 16'h8000;
    do_reset();
    s0 = s_rises;
    run = 1'b1;
    wait_halt(50, "illegal");
    run = 1'b0;
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got=%b want=1", illegal); end
    checks++; if (s_rises - s0 != 0) begin errors++; $display("FAIL ill_issues got=%0d want=0", s_rises - s0); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL ill_retired got=%0d want=0", retired); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL ill_pc got=%h want=01", pc); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ill_fault got=%b want=0", fault); end
  endtask

  task automatic test_watchdog();
    int n;
    fill_halt();
    mem[0] = 16'hD007;
    do_reset();
    core_hang = 1'b1;
    run = 1'b1;
    n = 0;
    while (!s && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (s && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!halted && n < 40) begin
      n++;
      @(negedge clk);
    end
    run = 1'b0;
    checks++; if (n != 16) begin errors++; $display("FAIL wd_exec_cycles got=%0d want=16", n); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL wd_fault got=%b want=1", fault); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL wd_halted got=%b want=1", halted); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL wd_s got=%b want=0", s); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL wd_retired got=%0d want=0", retired); end
    core_hang = 1'b0;
  endtask

  task automatic test_halt_req();
    int s0, n;
    fill_halt();
    mem[0] = 16'hD001;
    mem[1] = 16'hA123;
    mem[2] = 16'hC042;
    mem[3] = 16'hB7FF;
    mem[4] = 16'hD009;
    do_reset();
    core_lat = 5;
    s0 = s_rises;
    run = 1'b1;
    n = 0;
    while (!((s_rises - s0) == 3 && !s) && n < 200) begin
      @(negedge clk);
      n++;
    end
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    wait_halt(50, "hreq");
    run = 1'b0;
    checks++; if (retired !== 16'd3) begin errors++; $display("FAIL hreq_retired got=%0d want=3", retired); end
    checks++; if (pc !== 8'h03) begin errors++; $display("FAIL hreq_pc got=%h want=03", pc); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL hreq_illegal got=%b want=0", illegal); end
    mem[255] = 16'hD00F;
    mem[0] = 16'hE000;
    load_pc(8'hFF);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL wrap_halted_clr got=%b want=0", halted); end
    checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL wrap_pc_load got=%h want=FF", pc); end
    run = 1'b1;
    n = 0;
    while (!mem_rd && n < 10) begin @(negedge clk); n++; end
    checks++; if (mem_addr !== 8'hFF || mem_rd !== 1'b1) begin errors++; $display("FAIL wrap_fetch_addr got=%h/%b want=FF/1", mem_addr, mem_rd); end
    n = 0;
    while (!s && n < 10) begin @(negedge clk); n++; end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc got=%h want=00", pc); end
    wait_halt(50, "wrap");
    run = 1'b0;
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL wrap_end_pc got=%h want=01", pc); end
    checks++; if (retired !== 16'd4) begin errors++; $display("FAIL wrap_retired got=%0d want=4", retired); end
  endtask

  task automatic test_reset_mid();
    int n;
    fill_halt();
    mem[0] = 16'hD007;
    do_reset();
    core_hang = 1'b1;
    run = 1'b1;
    n = 0;
    while (!s && n < 20) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL rmid_s got=%b want=0", s); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL rmid_pc got=%h want=00", pc); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL rmid_ir got=%h want=0000", ir); end
    checks++; if ({halted, illegal, fault} !== 3'b000) begin errors++; $display("FAIL rmid_flags got=%b want=000", {halted, illegal, fault}); end
    reset = 1'b0;
    run = 1'b0;
    core_hang = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_rd !== 1'b0 || s !== 1'b0) begin errors++; $display("FAIL rmid_idle got=%b%b want=00", mem_rd, s); end
  endtask

  task automatic test_random();
    logic [7:0]  start, p;
    logic [15:0] ins, last;
    int len, ret, s0;
    bit ill;
    for (int it = 0; it < 10; it++) begin
      fill_halt();
      start = 8'($urandom_range(0, 255));
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) mem[8'(start + 8'(k))] = gen_instr();
      do_reset();
      core_lat = $urandom_range(1, 10);
      load_pc(start);
      s0 = s_rises;
      run = 1'b1;
      wait_halt(600, "rand");
      run = 1'b0;
      p = start;
      ret = 0;
      ill = 1'b0;
      last = 16'h0000;
      for (int g = 0; g < 300; g++) begin
        ins = mem[p];
        p = p + 8'd1;
        last = ins;
        if (ins[15:13] == 3'b111) break;
        if (!ref_legal(ins)) begin ill = 1'b1; break; end
        ret++;
      end
      checks++; if (pc !== p) begin errors++; $display("FAIL rand%0d_pc got=%h want=%h", it, pc, p); end
      checks++; if (retired !== 16'(ret)) begin errors++; $display("FAIL rand%0d_retired got=%0d want=%0d", it, retired, ret); end
      checks++; if (illegal !== ill) begin errors++; $display("FAIL rand%0d_illegal got=%b want=%b", it, illegal, ill); end
      checks++; if (s_rises - s0 != ret) begin errors++; $display("FAIL rand%0d_issues got=%0d want=%0d", it, s_rises - s0, ret); end
      checks++; if (ir !== last) begin errors++; $display("FAIL rand%0d_ir got=%h want=%h", it, ir, last); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rand%0d_fault got=%b want=0", it, fault); end
    end
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_step();
    test_illegal();
    test_watchdog();
    test_halt_req();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
